// File: rtl/wt_dcache_rd_miss_if.sv
// Bundled miss-request, memory-port and cache-write signals of the dcache read-miss unit.
// The unit itself connects through the slave modport; the requester/memory side uses master.
interface wt_dcache_rd_miss_if #(
  parameter int unsigned NumWays   = 8,
  parameter int unsigned LineWidth = 128,
  parameter int unsigned Plen      = 56,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned IdxWidth  = 8,
  parameter int unsigned TagWidth  = 44
);
  logic                 miss_req_i;
  logic                 miss_ack_o;
  logic                 miss_replay_o;
  logic                 miss_nc_i;
  logic                 miss_we_i;
  logic [NumWays-1:0]   miss_vld_bits_i;
  logic [Plen-1:0]      miss_paddr_i;
  logic [2:0]           miss_size_i;
  logic [IdWidth-1:0]   miss_id_i;
  logic                 miss_rtrn_vld_o;
  logic                 wbuffer_hit_i;
  logic                 flush_i;
  logic                 flush_ack_o;
  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic [Plen-1:0]      mem_paddr_o;
  logic [2:0]           mem_size_o;
  logic                 mem_nc_o;
  logic [IdWidth-1:0]   mem_id_o;
  logic                 mem_rtrn_vld_i;
  logic [IdWidth-1:0]   mem_rtrn_id_i;
  logic [LineWidth-1:0] mem_rtrn_data_i;
  logic                 wr_cl_vld_o;
  logic                 wr_cl_nc_o;
  logic [NumWays-1:0]   wr_cl_we_o;
  logic [IdxWidth-1:0]  wr_cl_idx_o;
  logic [TagWidth-1:0]  wr_cl_tag_o;
  logic [LineWidth-1:0] wr_cl_data_o;
  logic [NumWays-1:0]   wr_vld_bits_o;

  modport slave (
    input  miss_req_i, miss_nc_i, miss_we_i, miss_vld_bits_i, miss_paddr_i, miss_size_i,
           miss_id_i, wbuffer_hit_i, flush_i, mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
           mem_rtrn_data_i,
    output miss_ack_o, miss_replay_o, miss_rtrn_vld_o, flush_ack_o, mem_req_o, mem_paddr_o,
           mem_size_o, mem_nc_o, mem_id_o, wr_cl_vld_o, wr_cl_nc_o, wr_cl_we_o, wr_cl_idx_o,
           wr_cl_tag_o, wr_cl_data_o, wr_vld_bits_o
  );

  modport master (
    output miss_req_i, miss_nc_i, miss_we_i, miss_vld_bits_i, miss_paddr_i, miss_size_i,
           miss_id_i, wbuffer_hit_i, flush_i, mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
           mem_rtrn_data_i,
    input  miss_ack_o, miss_replay_o, miss_rtrn_vld_o, flush_ack_o, mem_req_o, mem_paddr_o,
           mem_size_o, mem_nc_o, mem_id_o, wr_cl_vld_o, wr_cl_nc_o, wr_cl_we_o, wr_cl_idx_o,
           wr_cl_tag_o, wr_cl_data_o, wr_vld_bits_o
  );
endinterface

// File: rtl/wt_dcache_rd_miss_unit.sv
// Read-miss responder of the write-through dcache: ack/replay decision, single outstanding
// memory transaction, victim refill, and whole-cache invalidation sweep on flush.
module wt_dcache_rd_miss_unit #(
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned LineWidth = 128,
  parameter int unsigned Plen      = 56,
  parameter int unsigned IdWidth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wt_dcache_rd_miss_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NumSets);
  localparam int unsigned OffW = $clog2(LineWidth / 8);
  localparam int unsigned TagW = Plen - IdxW - OffW;
  localparam int unsigned WayW = $clog2(NumWays);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  function automatic logic [WayW-1:0] first_invalid_way(input logic [NumWays-1:0] vld);
    logic [WayW-1:0] way;
    way = '0;
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        way = WayW'(i);
      end else begin
        way = way;
      end
    end
    return way;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_e             state_r;
  logic [7:0]         lfsr_r;
  logic [IdxW-1:0]    flush_cnt_r;
  logic               flush_done_r;
  logic               mem_req_r;
  logic [Plen-1:0]    paddr_r;
  logic [2:0]         size_r;
  logic               nc_r;
  logic [IdWidth-1:0] id_r;
  logic [WayW-1:0]    way_r;

  logic ack_s;
  logic replay_s;
  logic rtrn_match_s;
  logic flush_wr_s;
  logic unused_s;

  // Flush outranks a pending miss; while flushing the requester simply stalls.
  assign ack_s    = (state_r == IDLE) && !bus.flush_i && bus.miss_req_i && !bus.wbuffer_hit_i;
  assign replay_s = (state_r == IDLE) && !bus.flush_i && bus.miss_req_i &&  bus.wbuffer_hit_i;

  assign rtrn_match_s = (state_r == MEM_WAIT) && bus.mem_rtrn_vld_i && (bus.mem_rtrn_id_i == id_r);
  assign flush_wr_s   = (state_r == FLUSH) && !flush_done_r;
  assign unused_s     = bus.miss_we_i;

  assign bus.miss_ack_o      = ack_s;
  assign bus.miss_replay_o   = replay_s;
  assign bus.miss_rtrn_vld_o = rtrn_match_s;
  assign bus.flush_ack_o     = flush_done_r;
  assign bus.mem_req_o       = mem_req_r;
  assign bus.mem_paddr_o     = paddr_r;
  assign bus.mem_size_o      = size_r;
  assign bus.mem_nc_o        = nc_r;
  assign bus.mem_id_o        = id_r;

  // Control FSM with captured request, victim way, LFSR and flush sweep counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      lfsr_r       <= 8'hFF;
      flush_cnt_r  <= '0;
      flush_done_r <= 1'b0;
      mem_req_r    <= 1'b0;
      paddr_r      <= '0;
      size_r       <= 3'b000;
      nc_r         <= 1'b0;
      id_r         <= '0;
      way_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.flush_i) begin
            flush_cnt_r <= '0;
            state_r     <= FLUSH;
          end else if (ack_s) begin
            nc_r      <= bus.miss_nc_i;
            id_r      <= bus.miss_id_i;
            mem_req_r <= 1'b1;
            state_r   <= MEM_REQ;
            if (bus.miss_nc_i) begin
              paddr_r <= bus.miss_paddr_i;
              size_r  <= bus.miss_size_i;
            end else begin
              paddr_r <= {bus.miss_paddr_i[Plen-1:OffW], {OffW{1'b0}}};
              size_r  <= 3'b111;
              lfsr_r  <= lfsr_step(lfsr_r);
            end
            // Prefer an invalid way; only evict pseudo-randomly when the set is full.
            if (&bus.miss_vld_bits_i) begin
              way_r <= lfsr_r[WayW-1:0];
            end else begin
              way_r <= first_invalid_way(bus.miss_vld_bits_i);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MEM_REQ: begin
          if (bus.mem_gnt_i) begin
            mem_req_r <= 1'b0;
            state_r   <= MEM_WAIT;
          end else begin
            state_r <= MEM_REQ;
          end
        end
        MEM_WAIT: begin
          if (rtrn_match_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= MEM_WAIT;
          end
        end
        FLUSH: begin
          if (flush_done_r) begin
            flush_done_r <= 1'b0;
            flush_cnt_r  <= '0;
            state_r      <= IDLE;
          end else if (flush_cnt_r == IdxW'(NumSets - 1)) begin
            flush_done_r <= 1'b1;
          end else begin
            flush_cnt_r <= flush_cnt_r + IdxW'(1);
          end
        end
        default: begin
          mem_req_r    <= 1'b0;
          flush_done_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Cache-line write port: refill on a matching return, set invalidation during the sweep.
  always_comb begin
    bus.wr_cl_vld_o   = 1'b0;
    bus.wr_cl_nc_o    = 1'b0;
    bus.wr_cl_we_o    = '0;
    bus.wr_vld_bits_o = '0;
    bus.wr_cl_idx_o   = paddr_r[OffW +: IdxW];
    bus.wr_cl_tag_o   = paddr_r[Plen-1 -: TagW];
    bus.wr_cl_data_o  = '0;
    if (flush_wr_s) begin
      bus.wr_cl_vld_o = 1'b1;
      bus.wr_cl_we_o  = '1;
      bus.wr_cl_idx_o = flush_cnt_r;
    end else if (rtrn_match_s) begin
      bus.wr_cl_vld_o  = 1'b1;
      bus.wr_cl_nc_o   = nc_r;
      bus.wr_cl_data_o = bus.mem_rtrn_data_i;
      if (!nc_r) begin
        bus.wr_cl_we_o    = {{(NumWays-1){1'b0}}, 1'b1} << way_r;
        bus.wr_vld_bits_o = '1;
      end else begin
        bus.wr_cl_we_o    = '0;
        bus.wr_vld_bits_o = '0;
      end
    end else begin
      bus.wr_cl_vld_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_miss_unit.sv
// Scoreboard bench for wt_dcache_rd_miss_unit (NumSets=4): directed misses, replay, flush, reset abort.
module tb_wt_dcache_rd_miss_unit;
  logic clk;
  logic rst_ni;

  typedef struct {
    logic [55:0] pa;
    logic [2:0]  sz;
    logic        nc;
    logic [3:0]  id;
  } mem_t;

  typedef struct {
    logic         nc;
    logic [7:0]   we;
    logic [7:0]   vb;
    logic [1:0]   idx;
    logic [49:0]  tag;
    logic         chk_tag;
    logic [127:0] data;
    logic         rtrn;
  } wr_t;

  logic [1:0] resp_q[$];
  mem_t       mem_q[$];
  wr_t        wr_q[$];
  int         fack_pend = 0;
  int         checks    = 0;
  int         failures  = 0;

  wt_dcache_rd_miss_if #(.NumWays(8), .LineWidth(128), .Plen(56), .IdWidth(4),
                         .IdxWidth(2), .TagWidth(50)) bus ();

  wt_dcache_rd_miss_unit #(.NumSets(4), .NumWays(8), .LineWidth(128), .Plen(56), .IdWidth(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flush();
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back('{nc: 1'b0, we: 8'hFF, vb: 8'h00, idx: 2'(i), tag: 50'h0, chk_tag: 1'b0,
                       data: 128'h0, rtrn: 1'b0});
    end
    fack_pend++;
  endtask

  // Runs until flush_ack, drops flush_i, and returns at the start of the following IDLE cycle.
  task automatic finish_flush();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.flush_ack_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("flush_ack_seen", 128'(seen), 128'(1));
    bus.flush_i = 1'b0;
    tick();
  endtask

  task automatic do_miss(input logic [55:0] pa, input logic nc, input logic [2:0] sz,
                         input logic [3:0] id, input logic [7:0] vld, input logic [55:0] exp_pa,
                         input logic [2:0] exp_sz, input logic [7:0] exp_we, input logic [127:0] data,
                         input int replays, input int gnt_dly, input int rtn_dly,
                         input logic foreign, input logic early_rtn, input logic flush_mid);
    bus.miss_paddr_i    = pa;
    bus.miss_nc_i       = nc;
    bus.miss_size_i     = sz;
    bus.miss_id_i       = id;
    bus.miss_vld_bits_i = vld;
    bus.miss_req_i      = 1'b1;
    bus.wbuffer_hit_i   = (replays > 0);
    for (int r = 0; r < replays; r++) begin
      resp_q.push_back(2'b01);
      tick();
    end
    bus.wbuffer_hit_i = 1'b0;
    resp_q.push_back(2'b10);
    mem_q.push_back('{pa: exp_pa, sz: exp_sz, nc: nc, id: id});
    wr_q.push_back('{nc: nc, we: exp_we, vb: (nc ? 8'h00 : 8'hFF), idx: exp_pa[5:4],
                     tag: exp_pa[55:6], chk_tag: 1'b1, data: data, rtrn: 1'b1});
    if (flush_mid) push_flush();
    tick();
    bus.miss_req_i = 1'b0;
    if (flush_mid) bus.flush_i = 1'b1;
    repeat (gnt_dly) tick();
    bus.mem_gnt_i = 1'b1;
    if (early_rtn) begin
      bus.mem_rtrn_vld_i  = 1'b1;
      bus.mem_rtrn_id_i   = id;
      bus.mem_rtrn_data_i = ~data;
    end
    tick();
    bus.mem_gnt_i      = 1'b0;
    bus.mem_rtrn_vld_i = 1'b0;
    repeat (rtn_dly) tick();
    if (foreign) begin
      bus.mem_rtrn_vld_i  = 1'b1;
      bus.mem_rtrn_id_i   = id + 4'd1;
      bus.mem_rtrn_data_i = ~data;
      tick();
    end
    bus.mem_rtrn_vld_i  = 1'b1;
    bus.mem_rtrn_id_i   = id;
    bus.mem_rtrn_data_i = data;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack/replay, grant, write or flush ack.
  always @(negedge clk) begin : mon
    logic [1:0] r;
    mem_t m;
    wr_t  w;
    if (rst_ni) begin
      if (bus.miss_ack_o || bus.miss_replay_o) begin
        check("resp_expected", 128'(resp_q.size() > 0), 128'(1));
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          check("miss_ack", 128'(bus.miss_ack_o), 128'(r[1]));
          check("miss_replay", 128'(bus.miss_replay_o), 128'(r[0]));
        end
      end
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        check("mem_expected", 128'(mem_q.size() > 0), 128'(1));
        if (mem_q.size() > 0) begin
          m = mem_q.pop_front();
          check("mem_paddr", 128'(bus.mem_paddr_o), 128'(m.pa));
          check("mem_size", 128'(bus.mem_size_o), 128'(m.sz));
          check("mem_nc", 128'(bus.mem_nc_o), 128'(m.nc));
          check("mem_id", 128'(bus.mem_id_o), 128'(m.id));
        end
      end
      if (bus.wr_cl_vld_o) begin
        check("wr_expected", 128'(wr_q.size() > 0), 128'(1));
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_cl_nc", 128'(bus.wr_cl_nc_o), 128'(w.nc));
          check("wr_cl_we", 128'(bus.wr_cl_we_o), 128'(w.we));
          check("wr_vld_bits", 128'(bus.wr_vld_bits_o), 128'(w.vb));
          check("wr_cl_idx", 128'(bus.wr_cl_idx_o), 128'(w.idx));
          if (w.chk_tag) check("wr_cl_tag", 128'(bus.wr_cl_tag_o), 128'(w.tag));
          check("wr_cl_data", bus.wr_cl_data_o, w.data);
          check("miss_rtrn_vld", 128'(bus.miss_rtrn_vld_o), 128'(w.rtrn));
        end
      end else if (bus.miss_rtrn_vld_o) begin
        check("rtrn_without_wr", 128'(bus.wr_cl_vld_o), 128'(1));
      end
      if (bus.flush_ack_o) begin
        check("flush_ack_expected", 128'(fack_pend > 0), 128'(1));
        if (fack_pend > 0) fack_pend--;
      end
    end
  end

  initial begin
    rst_ni              = 1'b0;
    bus.miss_req_i      = 1'b0;
    bus.miss_nc_i       = 1'b0;
    bus.miss_we_i       = 1'b0;
    bus.miss_vld_bits_i = 8'h00;
    bus.miss_paddr_i    = 56'h0;
    bus.miss_size_i     = 3'b000;
    bus.miss_id_i       = 4'd0;
    bus.wbuffer_hit_i   = 1'b0;
    bus.flush_i         = 1'b0;
    bus.mem_gnt_i       = 1'b0;
    bus.mem_rtrn_vld_i  = 1'b0;
    bus.mem_rtrn_id_i   = 4'd0;
    bus.mem_rtrn_data_i = 128'h0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_mem_req", 128'(bus.mem_req_o), 128'(0));
    check("rst_mem_paddr", 128'(bus.mem_paddr_o), 128'(0));
    check("rst_mem_size", 128'(bus.mem_size_o), 128'(0));
    check("rst_mem_id", 128'(bus.mem_id_o), 128'(0));
    check("rst_wr_vld", 128'(bus.wr_cl_vld_o), 128'(0));
    check("rst_wr_idx", 128'(bus.wr_cl_idx_o), 128'(0));
    check("rst_flush_ack", 128'(bus.flush_ack_o), 128'(0));
    check("rst_rtrn_vld", 128'(bus.miss_rtrn_vld_o), 128'(0));
    tick();

    // Full set, LFSR 8'hFF -> way 7; grant in the first cycle.
    do_miss(56'h8000_0040, 1'b0, 3'b000, 4'd1, 8'hFF, 56'h8000_0040, 3'b111, 8'h80,
            {4{32'hA5A5_0001}}, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Full set again, LFSR 8'hFE -> way 6.
    do_miss(56'h8000_0457, 1'b0, 3'b010, 4'd2, 8'hFF, 56'h8000_0450, 3'b111, 8'h40,
            {4{32'h0BAD_F00D}}, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    // Lowest invalid way 3; foreign id 2 return is ignored before id 1.
    do_miss(56'h8000_1234, 1'b0, 3'b001, 4'd1, 8'hF7, 56'h8000_1230, 3'b111, 8'h08,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    // Two replay cycles, then ack once the write buffer clears; way 0.
    do_miss(56'h8000_2008, 1'b0, 3'b011, 4'd3, 8'h00, 56'h8000_2000, 3'b111, 8'h01,
            {4{32'hC0DE_0003}}, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    // Non-cacheable pass-through; a return in the grant cycle must be ignored.
    do_miss(56'h1000_0008, 1'b1, 3'b011, 4'd2, 8'h00, 56'h1000_0008, 3'b011, 8'h00,
            {4{32'h5555_AAAA}}, 0, 2, 1, 1'b0, 1'b1, 1'b0);

    // Flush in IDLE with a miss held: no ack or replay until the sweep is over.
    bus.miss_paddr_i    = 56'h8000_0300;
    bus.miss_nc_i       = 1'b0;
    bus.miss_size_i     = 3'b000;
    bus.miss_id_i       = 4'd4;
    bus.miss_vld_bits_i = 8'hFE;
    bus.miss_req_i      = 1'b1;
    bus.flush_i         = 1'b1;
    push_flush();
    finish_flush();
    do_miss(56'h8000_0300, 1'b0, 3'b000, 4'd4, 8'hFE, 56'h8000_0300, 3'b111, 8'h01,
            {4{32'h1111_2222}}, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Flush raised while a miss is outstanding: refill first, then the sweep.
    do_miss(56'h8000_0310, 1'b0, 3'b000, 4'd7, 8'hBF, 56'h8000_0310, 3'b111, 8'h40,
            {4{32'h3333_4444}}, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    finish_flush();

    // Reset in MEM_WAIT aborts the miss: no refill, outputs back to zero.
    bus.miss_paddr_i    = 56'h8000_3000;
    bus.miss_id_i       = 4'd5;
    bus.miss_vld_bits_i = 8'h00;
    bus.miss_req_i      = 1'b1;
    resp_q.push_back(2'b10);
    mem_q.push_back('{pa: 56'h8000_3000, sz: 3'b111, nc: 1'b0, id: 4'd5});
    tick();
    bus.miss_req_i = 1'b0;
    bus.mem_gnt_i  = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    rst_ni        = 1'b0;
    tick();
    bus.mem_rtrn_vld_i  = 1'b1;
    bus.mem_rtrn_id_i   = 4'd5;
    bus.mem_rtrn_data_i = {4{32'hDEAD_BEEF}};
    tick();
    check("mid_rst_mem_req", 128'(bus.mem_req_o), 128'(0));
    check("mid_rst_wr_vld", 128'(bus.wr_cl_vld_o), 128'(0));
    check("mid_rst_mem_paddr", 128'(bus.mem_paddr_o), 128'(0));
    check("mid_rst_rtrn_vld", 128'(bus.miss_rtrn_vld_o), 128'(0));
    rst_ni = 1'b1;
    tick();
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    tick();

    // LFSR is back at 8'hFF after reset -> way 7.
    do_miss(56'h8000_0500, 1'b0, 3'b000, 4'd6, 8'hFF, 56'h8000_0500, 3'b111, 8'h80,
            {4{32'h7777_8888}}, 0, 1, 0, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    check("resp_q_drained", 128'(resp_q.size()), 128'(0));
    check("mem_q_drained", 128'(mem_q.size()), 128'(0));
    check("wr_q_drained", 128'(wr_q.size()), 128'(0));
    check("flush_ack_drained", 128'(fack_pend), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
